// File: rtl/gate_unit_pkg.sv
// Shared opcode/mode encodings and the bitwise gate evaluator for the gate unit.
// gate_eval works at GATE_MAX_W bits; callers zero-extend and keep the low WIDTH bits.
package gate_unit_pkg;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  localparam logic [1:0] MODE_BIT  = 2'd0;
  localparam logic [1:0] MODE_RED  = 2'd1;
  localparam logic [1:0] MODE_ACC  = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;

  // Widest operand the unit supports.
  localparam int unsigned GATE_MAX_W = 64;

  function automatic logic [GATE_MAX_W-1:0] gate_eval(input logic [2:0]            op,
                                                      input logic [GATE_MAX_W-1:0] a,
                                                      input logic [GATE_MAX_W-1:0] b);
    logic [GATE_MAX_W-1:0] y;
    y = '0;
    unique case (op)
      OP_NAND: y = ~(a & b);
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_BUF:  y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_unit_fifo.sv
// Result FIFO for the gate unit: DEPTH entries (power of two), wrapping pointers.
// Head data reads as zero while empty.
module gate_unit_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q < CntW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/gate_unit_pipe.sv
// WIDTH-bit gate unit with bitwise/reduce/accumulate/load modes, valid/ready input
// and a DEPTH-entry result FIFO. WIDTH is limited to GATE_MAX_W.
module gate_unit_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc,
  output logic [15:0]      ops_done
);

  import gate_unit_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                  rdy_q;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [15:0]           ops_q, ops_d;
  logic [CntW-1:0]       count;
  logic                  accept;
  logic                  red;
  logic [WIDTH-1:0]      y;
  logic [GATE_MAX_W-1:0] bit_wide, acc_wide;
  logic [WIDTH:0]        head;
  logic                  unused_wide;

  // rdy_q holds in_ready low during reset and until the first edge after release.
  assign in_ready = rdy_q && (count < CntW'(DEPTH));
  assign accept   = in_valid && in_ready;

  assign bit_wide    = gate_eval(in_op, GATE_MAX_W'(in_a), GATE_MAX_W'(in_b));
  assign acc_wide    = gate_eval(in_op, GATE_MAX_W'(acc_q), GATE_MAX_W'(in_b));
  assign unused_wide = ^{bit_wide, acc_wide};

  always_comb begin
    red = 1'b0;
    unique case (in_op)
      OP_NAND: red = ~&in_a;
      OP_NOT:  red = ~in_a[0];
      OP_AND:  red = &in_a;
      OP_OR:   red = |in_a;
      OP_XOR:  red = ^in_a;
      OP_NOR:  red = ~|in_a;
      OP_XNOR: red = ~^in_a;
      OP_BUF:  red = in_a[0];
    endcase
  end

  always_comb begin
    y = '0;
    unique case (in_mode)
      MODE_BIT:  y = bit_wide[WIDTH-1:0];
      MODE_RED:  y = WIDTH'(red);
      MODE_ACC:  y = acc_wide[WIDTH-1:0];
      MODE_LOAD: y = in_a;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    ops_d = ops_q;
    if (accept) begin
      ops_d = ops_q + 16'd1;
      if (in_mode == MODE_ACC || in_mode == MODE_LOAD) acc_d = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      acc_q <= '0;
      ops_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      acc_q <= acc_d;
      ops_q <= ops_d;
    end
  end

  gate_unit_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (accept),
    .wdata_i ({(y == '0), y}),
    .pop_i   (out_valid && out_ready),
    .rdata_o (head),
    .valid_o (out_valid),
    .count_o (count)
  );

  assign out_y    = head[WIDTH-1:0];
  assign out_zero = head[WIDTH];
  assign acc      = acc_q;
  assign ops_done = ops_q;

endmodule
